// File: rtl/apb_slave.sv
// APB register slave: NO_REGS x DATA_WIDTH register file with byte strobes and range/alignment errors.
// Latency: one setup cycle, then WAIT_STATES access cycles before pready; back-to-back transfers need no idle cycle.
// Backpressure: pready is held low while the wait counter runs. Define APB_SLAVE_PROT_CHECK_EN to reject unprivileged upper-half writes.
module apb_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int NO_REGS     = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                    pclk,
    input  logic                    preset_n,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [2:0]              pprot,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic                    pready,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pslverr
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int REG_W = (NO_REGS > 1) ? $clog2(NO_REGS) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                  state;
    logic [3:0]              wait_cnt;
    logic [DATA_WIDTH-1:0]   regs [NO_REGS];

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    // Full word index (all upper address bits) for the range check; the
    // narrow select only picks a register once the access is known valid.
    logic [31:0]       word_idx;
    logic [REG_W-1:0]  reg_sel;
    logic              addr_err;
    logic              prot_err;
    logic              acc_err;
    logic              xfer_done;
    logic              wr_en;

    assign word_idx = 32'(paddr[ADDR_WIDTH-1:2]);
    assign reg_sel  = paddr[REG_W+1:2];
    assign addr_err = (paddr[1:0] != 2'b00) || (word_idx >= 32'(NO_REGS));

`ifdef APB_SLAVE_PROT_CHECK_EN
    // Upper half of the register file is writable only by privileged masters.
    logic unused_prot;
    assign unused_prot = ^pprot[2:1];
    assign prot_err    = pwrite && !pprot[0] && (word_idx >= 32'(NO_REGS / 2));
`else
    // Protection attributes play no part in access decode in this build.
    logic unused_prot;
    assign unused_prot = ^pprot;
    assign prot_err    = 1'b0;
`endif

    assign acc_err   = addr_err || prot_err;
    assign xfer_done = (state == ACCESS) && psel && penable && pready;
    assign wr_en     = xfer_done && pwrite && !acc_err;

    // ------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------
    // pready is registered and tracks (state == ACCESS && wait_cnt == 0):
    // it rises on entry when no wait states are configured, otherwise on
    // the edge where the counter steps from 1 to 0.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            pready   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A lone penable without a setup phase is not a transfer.
                    if (psel && !penable) begin
                        state    <= ACCESS;
                        wait_cnt <= 4'(WAIT_STATES);
                        pready   <= (WAIT_STATES == 0);
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        // Master abandoned the transfer: drop it without side effects.
                        state    <= IDLE;
                        wait_cnt <= 4'd0;
                        pready   <= 1'b0;
                    end else if (penable && pready) begin
                        // Completion; a setup phase in the next cycle is picked up from IDLE.
                        state    <= IDLE;
                        pready   <= 1'b0;
                    end else if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                        pready   <= (wait_cnt == 4'd1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    wait_cnt <= 4'd0;
                    pready   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    // Byte-strobed update on an error-free completing write only.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int r = 0; r < NO_REGS; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (pstrb[b]) begin
                    regs[reg_sel][8*b +: 8] <= pwdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response
    // ------------------------------------------------------------------
    // Read data and error are only presented in the completing cycle;
    // otherwise both are held at zero so the bus mux sees a quiet slave.
    always_comb begin
        prdata  = '0;
        pslverr = 1'b0;
        if (pready) begin
            if (acc_err) begin
                pslverr = 1'b1;
            end else if (!pwrite) begin
                prdata = regs[reg_sel];
            end
        end
    end

endmodule

// File: tb/tb_apb_slave.sv
// Directed bench for apb_slave: three instances (0, 2 and 3 wait states) share one APB bus with private psel.
// Table-driven transfers followed by hand sequences for abort, stray penable and reset mid-access.
// Expected values are hand-computed constants.
module tb_apb_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  sel;
    logic        penable;
    logic        pwrite;
    logic [9:0]  paddr;
    logic [2:0]  pprot;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;

    logic        rdy [3];
    logic [31:0] rd  [3];
    logic        err [3];

    int total = 0;
    int bad   = 0;

`ifdef APB_SLAVE_PROT_CHECK_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    always #5 clk = ~clk;

    apb_slave #(.WAIT_STATES(0)) u_ws0 (
        .pclk(clk), .preset_n(rst_n), .psel(sel[0]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pprot(pprot), .pwdata(pwdata), .pstrb(pstrb),
        .pready(rdy[0]), .prdata(rd[0]), .pslverr(err[0])
    );

    apb_slave #(.WAIT_STATES(2)) u_ws2 (
        .pclk(clk), .preset_n(rst_n), .psel(sel[1]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pprot(pprot), .pwdata(pwdata), .pstrb(pstrb),
        .pready(rdy[1]), .prdata(rd[1]), .pslverr(err[1])
    );

    apb_slave #(.WAIT_STATES(3)) u_ws3 (
        .pclk(clk), .preset_n(rst_n), .psel(sel[2]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pprot(pprot), .pwdata(pwdata), .pstrb(pstrb),
        .pready(rdy[2]), .prdata(rd[2]), .pslverr(err[2])
    );

    typedef struct {
        string       name;
        int          d;
        bit          wr;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          exp_waits;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input int d, input bit wr, input logic [9:0] addr,
                                input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                                input logic [31:0] exp_rd, input bit exp_err, input int exp_waits);
        vec_t v;
        v.name = name; v.d = d; v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
        v.prot = prot; v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_waits = exp_waits;
        return v;
    endfunction

    // Starts #1 after a rising edge with the setup phase; ends #1 after the
    // completion edge with the bus released, so calls chain back-to-back.
    task automatic xfer(input int d, input bit wr, input logic [9:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot,
                        output logic [31:0] rdata, output logic e, output int waits);
        bit found;
        sel     = 3'b000;
        sel[d]  = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        pstrb   = strb;
        pprot   = prot;
        @(posedge clk);
        #1 penable = 1'b1;
        waits = 0;
        found = 1'b0;
        rdata = 32'hxxxx_xxxx;
        e     = 1'bx;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rdy[d] === 1'b1) begin
                rdata = rd[d];
                e     = err[d];
                found = 1'b1;
                break;
            end
            chk("wait_prdata_zero", rd[d], 32'h0);
            chk("wait_pslverr_zero", 32'(err[d]), 32'h0);
            waits++;
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL pready_timeout: got no pready on dut %0d expected pready within 20 cycles", d);
        end
        @(posedge clk);
        #1;
        sel     = 3'b000;
        penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rdata;
        logic        e;
        int          waits;

        rst_n = 1'b0; sel = 3'b000; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pprot = '0; pwdata = '0; pstrb = '0;

        // Reset state of all three instances.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_pready_%0d", d), 32'(rdy[d]), 32'h0);
            chk($sformatf("reset_prdata_%0d", d), rd[d], 32'h0);
            chk($sformatf("reset_pslverr_%0d", d), 32'(err[d]), 32'h0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        //             name          d  wr addr    wdata          strb  prot  exp_rd                      err   waits
        tbl.push_back(mk("w004",      0, 1, 10'h004, 32'd2772003,   4'hF, 3'd1, 32'h0,                       1'b0, 0));
        tbl.push_back(mk("r004",      0, 0, 10'h004, 32'h0,         4'h0, 3'd0, 32'd2772003,                 1'b0, 0));
        tbl.push_back(mk("r008_ws2",  1, 0, 10'h008, 32'h0,         4'hF, 3'd0, 32'h0,                       1'b0, 2));
        tbl.push_back(mk("w00c_ones", 0, 1, 10'h00C, 32'hFFFFFFFF,  4'hF, 3'd0, 32'h0,                       1'b0, 0));
        tbl.push_back(mk("w00c_s5",   0, 1, 10'h00C, 32'h00000000,  4'h5, 3'd0, 32'h0,                       1'b0, 0));
        tbl.push_back(mk("r00c",      0, 0, 10'h00C, 32'h0,         4'hF, 3'd0, 32'hFF00FF00,                1'b0, 0));
        tbl.push_back(mk("w07d_unal", 0, 1, 10'h07D, 32'h12345678,  4'hF, 3'd1, 32'h0,                       1'b1, 0));
        tbl.push_back(mk("w100_rng",  0, 1, 10'h100, 32'h12345678,  4'hF, 3'd1, 32'h0,                       1'b1, 0));
        tbl.push_back(mk("w005_unal", 0, 1, 10'h005, 32'h00000000,  4'hF, 3'd1, 32'h0,                       1'b1, 0));
        tbl.push_back(mk("r004_keep", 0, 0, 10'h004, 32'h0,         4'hF, 3'd0, 32'd2772003,                 1'b0, 0));
        tbl.push_back(mk("r00c_keep", 0, 0, 10'h00C, 32'h0,         4'hF, 3'd0, 32'hFF00FF00,                1'b0, 0));
        tbl.push_back(mk("r07d_err",  0, 0, 10'h07D, 32'h0,         4'hF, 3'd0, 32'h0,                       1'b1, 0));
        tbl.push_back(mk("r03c_last", 0, 0, 10'h03C, 32'h0,         4'hF, 3'd0, 32'h0,                       1'b0, 0));
        tbl.push_back(mk("r040_over", 0, 0, 10'h040, 32'h0,         4'hF, 3'd0, 32'h0,                       1'b1, 0));
        tbl.push_back(mk("w010_s0",   0, 1, 10'h010, 32'hAAAA5555,  4'h0, 3'd1, 32'h0,                       1'b0, 0));
        tbl.push_back(mk("r010",      0, 0, 10'h010, 32'h0,         4'hF, 3'd0, 32'h0,                       1'b0, 0));
        tbl.push_back(mk("w020_p0",   0, 1, 10'h020, 32'hDEADBEEF,  4'hF, 3'd0, 32'h0,                       PROT, 0));
        tbl.push_back(mk("r020_a",    0, 0, 10'h020, 32'h0,         4'hF, 3'd0, PROT ? 32'h0 : 32'hDEADBEEF, 1'b0, 0));
        tbl.push_back(mk("w020_p1",   0, 1, 10'h020, 32'h0BADF00D,  4'hF, 3'd1, 32'h0,                       1'b0, 0));
        tbl.push_back(mk("r020_b",    0, 0, 10'h020, 32'h0,         4'hF, 3'd0, 32'h0BADF00D,                1'b0, 0));
        tbl.push_back(mk("w008_ws2",  1, 1, 10'h008, 32'h00000012,  4'hF, 3'd1, 32'h0,                       1'b0, 2));
        tbl.push_back(mk("r008_ws2b", 1, 0, 10'h008, 32'h0,         4'hF, 3'd0, 32'h00000012,                1'b0, 2));
        tbl.push_back(mk("w07d_ws2",  1, 1, 10'h07D, 32'h11111111,  4'hF, 3'd1, 32'h0,                       1'b1, 2));
        tbl.push_back(mk("r03c_ws3",  2, 0, 10'h03C, 32'h0,         4'hF, 3'd0, 32'h0,                       1'b0, 3));

        foreach (tbl[k]) begin
            xfer(tbl[k].d, tbl[k].wr, tbl[k].addr, tbl[k].wdata, tbl[k].strb, tbl[k].prot, rdata, e, waits);
            chk({tbl[k].name, "_prdata"}, rdata, tbl[k].exp_rd);
            chk({tbl[k].name, "_pslverr"}, 32'(e), 32'(tbl[k].exp_err));
            chk({tbl[k].name, "_waits"}, 32'(waits), 32'(tbl[k].exp_waits));
        end

        // Abort: psel dropped during the wait phase of a 3-wait-state write.
        sel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 10'h014;
        pwdata = 32'h00000055; pstrb = 4'hF; pprot = 3'd1;
        @(posedge clk);
        #1 penable = 1'b1;
        @(negedge clk);
        chk("abort_wait_pready", 32'(rdy[2]), 32'h0);
        @(posedge clk);
        #1 sel = 3'b000; penable = 1'b0;
        @(negedge clk);
        chk("abort_drop_pready", 32'(rdy[2]), 32'h0);
        @(posedge clk);
        #1;
        xfer(2, 1'b0, 10'h014, 32'h0, 4'hF, 3'd0, rdata, e, waits);
        chk("abort_r014_prdata", rdata, 32'h0);
        chk("abort_r014_waits", 32'(waits), 32'd3);

        // penable asserted in IDLE without a setup phase is ignored.
        sel = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 10'h018;
        pwdata = 32'h00000077; pstrb = 4'hF; pprot = 3'd1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("stray_penable_pready_%0d", c), 32'(rdy[0]), 32'h0);
            @(posedge clk);
            #1;
        end
        sel = 3'b000; penable = 1'b0;
        xfer(0, 1'b0, 10'h018, 32'h0, 4'hF, 3'd0, rdata, e, waits);
        chk("stray_r018_prdata", rdata, 32'h0);

        // Reset pulse in the completing cycle of a zero-wait write.
        sel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 10'h01C;
        pwdata = 32'h00000099; pstrb = 4'hF; pprot = 3'd1;
        @(posedge clk);
        #1 penable = 1'b1;
        @(negedge clk);
        chk("rst_mid_pready_before", 32'(rdy[0]), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_mid_pready_%0d", d), 32'(rdy[d]), 32'h0);
            chk($sformatf("rst_mid_prdata_%0d", d), rd[d], 32'h0);
            chk($sformatf("rst_mid_pslverr_%0d", d), 32'(err[d]), 32'h0);
        end
        @(posedge clk);
        #1 sel = 3'b000; penable = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        xfer(0, 1'b0, 10'h01C, 32'h0, 4'hF, 3'd0, rdata, e, waits);
        chk("rst_r01c_prdata", rdata, 32'h0);
        xfer(0, 1'b0, 10'h004, 32'h0, 4'hF, 3'd0, rdata, e, waits);
        chk("rst_r004_cleared", rdata, 32'h0);
        xfer(1, 1'b0, 10'h008, 32'h0, 4'hF, 3'd0, rdata, e, waits);
        chk("rst_r008_ws2_cleared", rdata, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_slave.md
APB_SLAVE -- requirements
Module: apb_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, APB data bus width, a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, APB byte-address width.
REQ-003 SHALL have parameter NO_REGS, default 16, number of DATA_WIDTH-wide registers, a power of two, NO_REGS*4 <= 2**ADDR_WIDTH.
REQ-004 SHALL have parameter WAIT_STATES, default 0, range 0..15, wait cycles inserted before pready.
REQ-005 SHALL have port pclk, input, 1 bit, sole clock, rising-edge.
REQ-006 SHALL have port preset_n, input, 1 bit; reset is asynchronous and active-low.
REQ-007 SHALL have port psel, input, 1 bit, this slave selected.
REQ-008 SHALL have port penable, input, 1 bit, access phase.
REQ-009 SHALL have port pwrite, input, 1 bit, 1=write, 0=read.
REQ-010 SHALL have port paddr, input, ADDR_WIDTH, byte address.
REQ-011 SHALL have port pprot, input, 3 bits, protection; bit 0 = privileged.
REQ-012 SHALL have port pwdata, input, DATA_WIDTH, write data.
REQ-013 SHALL have port pstrb, input, DATA_WIDTH/8, write byte strobes.
REQ-014 SHALL have port pready, output, 1 bit, transfer completes this cycle.
REQ-015 SHALL have port prdata, output, DATA_WIDTH, read data.
REQ-016 SHALL have port pslverr, output, 1 bit, transfer error.

Function
REQ-017 SHALL implement FSM states IDLE and ACCESS plus a 4-bit wait counter.
REQ-018 IDLE: on psel=1 and penable=0, SHALL go to ACCESS and load the counter with WAIT_STATES.
REQ-019 ACCESS: counter nonzero SHALL decrement by 1 per cycle; pready SHALL be 1 only when state=ACCESS and counter=0.
REQ-020 With WAIT_STATES=0, pready SHALL be 1 in the first access cycle, after the setup cycle.
REQ-021 A transfer SHALL complete at the rising edge where psel=1, penable=1 and pready=1, and the FSM SHALL then return to IDLE.
REQ-022 Register index SHALL be paddr[ADDR_WIDTH-1:2].
REQ-023 An access SHALL be in error if paddr[1:0]!=0 or index >= NO_REGS.
REQ-024 A completing error-free write SHALL update only the bytes whose pstrb bit is 1; a write with pstrb=0 leaves the register unchanged without error.
REQ-025 A write in error SHALL leave every register unchanged.
REQ-026 Reads SHALL ignore pstrb and SHALL not modify state.
REQ-027 prdata SHALL equal the addressed register when pready=1 on an error-free read, and 0 otherwise.
REQ-028 pslverr SHALL be 1 only when pready=1 and the access is in error, and 0 otherwise.
REQ-029 If psel falls while in ACCESS before completion, SHALL abort to IDLE with no register update.
REQ-030 Back-to-back transfers, where a setup phase immediately follows completion, SHALL be accepted with no idle cycle.
REQ-031 In IDLE, penable=1 without a preceding setup phase SHALL be ignored.

Reset
REQ-032 preset_n=0 SHALL immediately force state=IDLE, counter=0, all registers=0, pready=0, prdata=0 and pslverr=0.
REQ-033 A reset asserted mid-transfer SHALL discard the transfer with no register update.

Configuration
REQ-034 Macro APB_SLAVE_PROT_CHECK_EN, when defined, SHALL flag as an error any write with pprot[0]=0 to index >= NO_REGS/2.
REQ-035 Such a protection-error write SHALL set pslverr=1 at completion and leave registers unchanged; reads SHALL be unaffected.
REQ-036 Without the macro, pprot SHALL be ignored entirely.

Verification
REQ-037 WAIT_STATES=0: write paddr=0x004, pwdata=2772003, pstrb=4'b1111 -> pready=1 in the first access cycle, pslverr=0; a following read of 0x004 returns 2772003.
REQ-038 WAIT_STATES=2: read paddr=0x008 -> pready=0 for 2 access cycles, then 1; prdata=0 after reset.
REQ-039 Write 0xFFFFFFFF then write 0x00000000 with pstrb=4'b0101 to 0x00C -> read returns 0xFF00FF00.
REQ-040 Write to 0x07D (unaligned) and 0x100 (index 64 >= 16) -> pslverr=1 with pready; registers unchanged.
REQ-041 Drop psel mid-wait with WAIT_STATES=3 during a write -> FSM returns to IDLE and the register is unchanged; reset pulse mid-access -> all outputs 0.
REQ-042 With APB_SLAVE_PROT_CHECK_EN: write 0x020 with pprot=3'b000 -> pslverr=1; with pprot=3'b001 -> pslverr=0 and the data is stored.
